imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-master arbiter sharing the single IMEM Wishbone-style slave port between the boot loader (master 0: writes program words, reads them back for verification) and the CPU instruction-fetch port (master 1: read-only). It grants one master at a time, holds the grant until the slave acks, then waits for the owner to drop `cyc`. A per-transaction watchdog returns an error instead of hanging the bus. While boot mode is active, all CPU fetches are locked out.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, cycles a granted transaction may wait for `i_s_ack` before being errored; legal range 1..65535
---
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_boot_mode`  in  1  high while the boot loader holds the CPU in reset; master 1 is never granted while high
- `i_m0_cyc`  in  1  boot master request
- `i_m0_we`  in  1  boot master write enable
- `i_m0_adr`  in  AW  boot master address
- `i_m0_dat`  in  DW  boot master write data
- `o_m0_ack`  out  1  boot master acknowledge
- `o_m0_err`  out  1  boot master watchdog error, one-cycle pulse
- `i_m1_cyc`  in  1  CPU fetch request
- `i_m1_adr`  in  AW  CPU fetch address
- `o_m1_ack`  out  1  CPU fetch acknowledge
- `o_m1_err`  out  1  CPU fetch watchdog error, one-cycle pulse
- `o_m_dat`  out  DW  read data; `i_s_dat` broadcast to both masters
- `o_s_cyc`  out  1  slave request
- `o_s_we`  out  1  slave write enable
- `o_s_adr`  out  AW  slave address
- `o_s_dat`  out  DW  slave write data
- `i_s_ack`  in  1  slave acknowledge
- `i_s_dat`  in  DW  slave read data
- `o_owner`  out  2  current grant: 2'b00 none, 2'b01 master 0, 2'b10 master 1

## Operation
- States: IDLE, OWN0, OWN1, REL. Registers:
  - `state`
  - `rel_m` (which master REL is waiting on)
  - `last` (master most recently granted)
  - 16-bit `wcnt`
- Reset values: `state` = IDLE, `last` = master 1, `wcnt` = 0. All outputs are derived from state, so every output resets to 0.
- IDLE arbitration, using `req1 = i_m1_cyc & ~i_boot_mode`:
  - `i_m0_cyc` and not `req1` -> OWN0.
  - `req1` and not `i_m0_cyc` -> OWN1.
  - Both -> grant the master not equal to `last` (round robin); the first tie after reset goes to master 0.
  - Neither -> stay in IDLE.
  - On entering OWNx: `last` <= x, `wcnt` <= 0.
- OWNx:
  - `o_s_cyc` = `i_mx_cyc`. `o_s_we` = `i_m0_we` in OWN0, 0 in OWN1.
  - `o_s_adr`/`o_s_dat` are muxed from the owner. `o_s_dat` = 0 in OWN1.
  - `o_mx_ack` = `i_s_ack`, combinational. The other master's ack/err stay 0.
  - `i_s_ack` -> REL with `rel_m` = x.
  - Owner drops `cyc` without an ack (abort) -> IDLE directly.
  - Otherwise `wcnt` increments. When `wcnt` == TIMEOUT-1 and no ack: `o_mx_err` = 1 that cycle, `o_s_cyc` forced to 0 that cycle, next state REL.
  - Ack and timeout in the same cycle: ack wins; no err.
- REL:
  - `o_s_cyc` = 0, `o_owner` = 0.
  - Stays until `i_m{rel_m}_cyc` == 0, then -> IDLE.
  - This absorbs masters that register `cyc <= ~ack` and so hold `cyc` one cycle past ack. A transfer is never duplicated.
- Outside OWNx, the slave-side address/data/we outputs are 0.
- `o_owner` = 2'b01 in OWN0, 2'b10 in OWN1, else 2'b00.
- `i_boot_mode` rising while in OWN1: the fetch completes normally. Master 1 is never regranted until `i_boot_mode` falls.
- `rst` asserted mid-transaction: immediate return to IDLE. `o_s_cyc` drops asynchronously. No ack or err is emitted.

## Timing
- Grant latency: `cyc` sampled high in IDLE at edge N -> `o_s_cyc` high in cycle N+1.
- Ack/data pass-through: zero cycles, combinational from `i_s_ack`/`i_s_dat`.
- Best case, zero-wait slave with a registered-cyc master:
  - request seen in IDLE at N
  - ack in N+1
  - REL in N+2 (owner `cyc` low)
  - IDLE in N+3
  - next grant in N+4
- Watchdog: err pulses in the TIMEOUT-th cycle of OWNx (`wcnt` == TIMEOUT-1). TIMEOUT=1 errors in the first owned cycle unless ack is present.
- Minimum one non-OWN cycle between any two grants. No back-to-back grant.

## Test plan
- Boot write: `i_boot_mode`=1, m0 writes adr 0x0000_0010, dat 0xDEAD_BEEF, slave acks after 2 wait cycles -> slave sees exactly one write with those values; `o_m0_ack` for 1 cycle; m0 holds `cyc` one cycle past ack -> no second `o_s_cyc`.
- Lockout: `i_boot_mode`=1, m1 requests continuously for 50 cycles -> `o_s_cyc` never high for m1, `o_owner` never 2'b10; drop `i_boot_mode` -> m1 granted exactly 1 cycle later.
- Round robin: `i_boot_mode`=0, both request continuously, slave acks immediately -> grant order m0, m1, m0, m1; 4 acks in ≤16 cycles.
- Watchdog: TIMEOUT=4, m1 fetches, slave never acks -> `o_m1_err` high exactly in 4th owned cycle, `o_s_cyc` low that cycle, REL until m1 drops `cyc`, then IDLE.
- Ack/timeout collision: TIMEOUT=3, slave acks in 3rd owned cycle -> `o_m1_ack`=1, `o_m1_err`=0, `i_s_dat` 0x1234_5678 on `o_m_dat`.
- Reset mid-transaction: assert `rst` while in OWN0 -> `o_s_cyc`, `o_owner`, acks, errs all 0 before the next clock edge; after release, a pending m1 request (`i_boot_mode`=0) is granted in the 2nd cycle.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the IMEM arbiter, its two masters and the shared slave.
// The "slave" modport is the arbiter's view; "master" is the surrounding system's view.
`default_nettype none

interface imem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_m0_cyc;
  logic          i_m0_we;
  logic [AW-1:0] i_m0_adr;
  logic [DW-1:0] i_m0_dat;
  logic          o_m0_ack;
  logic          o_m0_err;
  logic          i_m1_cyc;
  logic [AW-1:0] i_m1_adr;
  logic          o_m1_ack;
  logic          o_m1_err;
  logic [DW-1:0] o_m_dat;
  logic          o_s_cyc;
  logic          o_s_we;
  logic [AW-1:0] o_s_adr;
  logic [DW-1:0] o_s_dat;
  logic          i_s_ack;
  logic [DW-1:0] i_s_dat;

  modport slave (
    input  i_m0_cyc, i_m0_we, i_m0_adr, i_m0_dat, i_m1_cyc, i_m1_adr, i_s_ack, i_s_dat,
    output o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_m_dat, o_s_cyc, o_s_we, o_s_adr, o_s_dat
  );

  modport master (
    output i_m0_cyc, i_m0_we, i_m0_adr, i_m0_dat, i_m1_cyc, i_m1_adr, i_s_ack, i_s_dat,
    input  o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_m_dat, o_s_cyc, o_s_we, o_s_adr, o_s_dat
  );
endinterface

`default_nettype wire

// File: rtl/imem_arbiter.sv
// Round-robin arbiter for the IMEM slave port: boot loader (m0) vs CPU fetch (m1),
// with a per-transaction watchdog and CPU lockout during boot mode.
`default_nettype none

module imem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_boot_mode,
  imem_arbiter_if.slave   bus,
  output logic [1:0]      o_owner
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  OWN0  = 2'd1;
  localparam logic [1:0]  OWN1  = 2'd2;
  localparam logic [1:0]  REL   = 2'd3;
  localparam logic [15:0] WLAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        rel_m_q, rel_m_d;
  logic        last_q, last_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        req1, own_cyc, rel_cyc, timeout;

  always_comb begin
    req1    = bus.i_m1_cyc & ~i_boot_mode;
    own_cyc = (state_q == OWN1) ? bus.i_m1_cyc : bus.i_m0_cyc;
    rel_cyc = rel_m_q ? bus.i_m1_cyc : bus.i_m0_cyc;
    // Ack in the final watchdog cycle wins over the error.
    timeout = own_cyc & ~bus.i_s_ack & (wcnt_q == WLAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rel_m_q <= 1'b0;
      last_q  <= 1'b1;
      wcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      rel_m_q <= rel_m_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rel_m_d = rel_m_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        // On a tie, m0 wins only if m1 was granted most recently.
        if (bus.i_m0_cyc && (!req1 || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
          wcnt_d  = 16'd0;
        end else if (req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
          wcnt_d  = 16'd0;
        end
      end
      OWN0, OWN1: begin
        if (bus.i_s_ack) begin
          state_d = REL;
          rel_m_d = (state_q == OWN1);
        end else if (!own_cyc) begin
          state_d = IDLE;
        end else if (wcnt_q == WLAST) begin
          state_d = REL;
          rel_m_d = (state_q == OWN1);
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: begin
        if (!rel_cyc) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    o_owner      = 2'b00;
    bus.o_s_cyc  = 1'b0;
    bus.o_s_we   = 1'b0;
    bus.o_s_adr  = '0;
    bus.o_s_dat  = '0;
    bus.o_m0_ack = 1'b0;
    bus.o_m0_err = 1'b0;
    bus.o_m1_ack = 1'b0;
    bus.o_m1_err = 1'b0;
    bus.o_m_dat  = '0;
    case (state_q)
      OWN0: begin
        o_owner      = 2'b01;
        bus.o_s_cyc  = bus.i_m0_cyc & ~timeout;
        bus.o_s_we   = bus.i_m0_we;
        bus.o_s_adr  = bus.i_m0_adr;
        bus.o_s_dat  = bus.i_m0_dat;
        bus.o_m0_ack = bus.i_s_ack;
        bus.o_m0_err = timeout;
        bus.o_m_dat  = bus.i_s_dat;
      end
      OWN1: begin
        o_owner      = 2'b10;
        bus.o_s_cyc  = bus.i_m1_cyc & ~timeout;
        bus.o_s_adr  = bus.i_m1_adr;
        bus.o_m1_ack = bus.i_s_ack;
        bus.o_m1_err = timeout;
        bus.o_m_dat  = bus.i_s_dat;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: boot write, lockout, round robin, watchdog,
// ack/timeout collision and asynchronous reset.
`default_nettype none

module tb_imem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       boot_a = 1'b0;
  logic       boot_b = 1'b0;
  logic [1:0] owner_a, owner_b;
  logic       auto_ack = 1'b0;
  logic       man_ack  = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         wr_cnt = 0;
  logic [31:0] wr_adr = '0;
  logic [31:0] wr_dat = '0;

  imem_arbiter_if #(.AW(32), .DW(32)) a_bus ();
  imem_arbiter_if #(.AW(32), .DW(32)) b_bus ();

  imem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .i_boot_mode(boot_a), .bus(a_bus), .o_owner(owner_a)
  );
  imem_arbiter #(.AW(32), .DW(32), .TIMEOUT(3)) dut_b (
    .clk(clk), .rst(rst), .i_boot_mode(boot_b), .bus(b_bus), .o_owner(owner_b)
  );

  always #5 clk = ~clk;

  // Zero-wait slave when auto_ack is set, otherwise directed ack.
  assign a_bus.i_s_ack = auto_ack ? a_bus.o_s_cyc : man_ack;

  always @(negedge clk)
    if (!rst && a_bus.o_s_cyc && a_bus.o_s_we && a_bus.i_s_ack) begin
      wr_cnt <= wr_cnt + 1;
      wr_adr <= a_bus.o_s_adr;
      wr_dat <= a_bus.o_s_dat;
    end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       bad;
    logic       p0, p1;
    logic [1:0] order [8];
    int         nack;

    a_bus.i_m0_cyc = 0; a_bus.i_m0_we = 0; a_bus.i_m0_adr = '0; a_bus.i_m0_dat = '0;
    a_bus.i_m1_cyc = 0; a_bus.i_m1_adr = '0; a_bus.i_s_dat = '0;
    b_bus.i_m0_cyc = 0; b_bus.i_m0_we = 0; b_bus.i_m0_adr = '0; b_bus.i_m0_dat = '0;
    b_bus.i_m1_cyc = 0; b_bus.i_m1_adr = '0; b_bus.i_s_ack = 0; b_bus.i_s_dat = '0;

    // Reset state
    #1;
    check("rst_s_cyc", a_bus.o_s_cyc, 0);
    check("rst_owner", owner_a, 2'b00);
    tick(); tick();
    rst = 1'b0;

    // Boot write with two wait cycles; m0 holds cyc one cycle past ack
    boot_a = 1; a_bus.i_m0_cyc = 1; a_bus.i_m0_we = 1;
    a_bus.i_m0_adr = 32'h0000_0010; a_bus.i_m0_dat = 32'hDEAD_BEEF;
    #1 check("boot_idle_owner", owner_a, 2'b00);
    tick();
    check("boot_grant_cyc", a_bus.o_s_cyc, 1);
    check("boot_grant_owner", owner_a, 2'b01);
    check("boot_adr", a_bus.o_s_adr, 32'h0000_0010);
    check("boot_dat", a_bus.o_s_dat, 32'hDEAD_BEEF);
    check("boot_we", a_bus.o_s_we, 1);
    tick();
    check("boot_wait_ack", a_bus.o_m0_ack, 0);
    tick();
    man_ack = 1;
    #1 check("boot_ack", a_bus.o_m0_ack, 1);
    check("boot_ack_err", a_bus.o_m0_err, 0);
    tick();
    man_ack = 0;
    #1 check("boot_rel_cyc", a_bus.o_s_cyc, 0);
    check("boot_rel_ack", a_bus.o_m0_ack, 0);
    tick();
    check("boot_rel_hold_cyc", a_bus.o_s_cyc, 0);
    a_bus.i_m0_cyc = 0; a_bus.i_m0_we = 0;
    tick();
    check("boot_idle_cyc", a_bus.o_s_cyc, 0);
    check("boot_wr_cnt", wr_cnt, 1);
    check("boot_wr_adr", wr_adr, 32'h0000_0010);
    check("boot_wr_dat", wr_dat, 32'hDEAD_BEEF);

    // Lockout: m1 requests for 50 cycles under boot mode
    a_bus.i_m1_cyc = 1; a_bus.i_m1_adr = 32'h0000_0400;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      #1 bad = bad | (owner_a == 2'b10) | a_bus.o_s_cyc;
      tick();
    end
    check("lockout_never_granted", bad, 0);
    boot_a = 0;
    #1 check("lockout_release_same_cycle", owner_a, 2'b00);
    tick();
    check("lockout_grant_owner", owner_a, 2'b10);
    check("lockout_grant_cyc", a_bus.o_s_cyc, 1);
    check("lockout_grant_adr", a_bus.o_s_adr, 32'h0000_0400);
    man_ack = 1; a_bus.i_s_dat = 32'hCAFE_0001;
    #1 check("fetch_ack", a_bus.o_m1_ack, 1);
    check("fetch_m0_ack", a_bus.o_m0_ack, 0);
    check("fetch_dat", a_bus.o_m_dat, 32'hCAFE_0001);
    tick();
    man_ack = 0; a_bus.i_m1_cyc = 0;
    tick();

    // Round robin: registered masters (cyc <= ~ack), zero-wait slave
    auto_ack = 1; nack = 0; p0 = 0; p1 = 0;
    for (int i = 0; i < 16; i++) begin
      a_bus.i_m0_cyc = ~p0;
      a_bus.i_m1_cyc = ~p1;
      #1;
      p0 = a_bus.o_m0_ack;
      p1 = a_bus.o_m1_ack;
      if ((p0 || p1) && nack < 8) begin
        order[nack] = {p1, p0};
        nack++;
      end
      tick();
    end
    check("rr_ack_count_ge4", nack >= 4, 1);
    check("rr_order0", order[0], 2'b01);
    check("rr_order1", order[1], 2'b10);
    check("rr_order2", order[2], 2'b01);
    check("rr_order3", order[3], 2'b10);
    auto_ack = 0; a_bus.i_m0_cyc = 0; a_bus.i_m1_cyc = 0;
    tick(); tick(); tick();
    check("rr_drain_owner", owner_a, 2'b00);

    // Watchdog, TIMEOUT=4, slave never acks
    a_bus.i_m1_cyc = 1;
    tick();
    check("wd_c1_err", a_bus.o_m1_err, 0);
    check("wd_c1_cyc", a_bus.o_s_cyc, 1);
    tick();
    check("wd_c2_err", a_bus.o_m1_err, 0);
    tick();
    check("wd_c3_err", a_bus.o_m1_err, 0);
    tick();
    check("wd_c4_err", a_bus.o_m1_err, 1);
    check("wd_c4_cyc", a_bus.o_s_cyc, 0);
    check("wd_c4_ack", a_bus.o_m1_ack, 0);
    tick();
    check("wd_rel_err", a_bus.o_m1_err, 0);
    check("wd_rel_owner", owner_a, 2'b00);
    tick();
    check("wd_rel_hold_cyc", a_bus.o_s_cyc, 0);
    a_bus.i_m1_cyc = 0;
    tick();
    check("wd_idle_owner", owner_a, 2'b00);

    // Ack/timeout collision on the TIMEOUT=3 instance
    b_bus.i_m1_cyc = 1;
    tick();
    check("col_c1_owner", owner_b, 2'b10);
    tick();
    tick();
    b_bus.i_s_ack = 1; b_bus.i_s_dat = 32'h1234_5678;
    #1 check("col_ack", b_bus.o_m1_ack, 1);
    check("col_err", b_bus.o_m1_err, 0);
    check("col_dat", b_bus.o_m_dat, 32'h1234_5678);
    check("col_cyc", b_bus.o_s_cyc, 1);
    tick();
    b_bus.i_s_ack = 0; b_bus.i_m1_cyc = 0;
    tick();

    // Asynchronous reset while m0 owns the bus, m1 pending
    a_bus.i_m0_cyc = 1;
    tick();
    check("rst_pre_owner", owner_a, 2'b01);
    a_bus.i_m1_cyc = 1; man_ack = 1;
    #1 rst = 1;
    #1 check("rst_async_cyc", a_bus.o_s_cyc, 0);
    check("rst_async_owner", owner_a, 2'b00);
    check("rst_async_acks", {a_bus.o_m0_ack, a_bus.o_m1_ack}, 2'b00);
    check("rst_async_errs", {a_bus.o_m0_err, a_bus.o_m1_err}, 2'b00);
    man_ack = 0; a_bus.i_m0_cyc = 0;
    tick();
    rst = 0;
    #1 check("rst_rel_c1_owner", owner_a, 2'b00);
    tick();
    check("rst_rel_c2_owner", owner_a, 2'b10);
    check("rst_rel_c2_cyc", a_bus.o_s_cyc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
